fifo_flow_ctrl: RTL and testbench

Flow-control front/back end for the v3 raw synchronous FIFO. It converts an upstream valid/ready enqueue stream and a downstream valid/ready dequeue stream into the FIFO's unguarded push and pop strobes. It keeps the occupancy count, full/empty status and a high-water mark, and holds one registered output word so that deq_msg is glitch-free. It sits directly around the FIFO: its push outputs drive the FIFO write side, and its pop input/output connect to the FIFO read side.

---
 rtl/fifo_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_fifo_flow_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl
//
// Flow-control wrapper for a raw synchronous FIFO (no internal guarding).
// Turns an upstream valid/ready enqueue stream and a downstream valid/ready
// dequeue stream into unguarded push/pop strobes for the FIFO. It tracks
// occupancy, full/empty and a high-water mark, and keeps one registered
// output word so that deq_msg never glitches.
//
// Parameters
//   p_num_entries : FIFO depth (power of two, >= 2); must match the FIFO.
//   p_bit_width   : message width.
//
// Ports (c_cw = $clog2(p_num_entries)+1)
//   clk           in   1            clock, rising edge
//   reset         in   1            asynchronous, active-high reset
//   enq_msg       in   p_bit_width  upstream message
//   enq_val       in   1            upstream valid
//   enq_rdy       out  1            upstream ready
//   fifo_push     out  1            FIFO write strobe (istream_val)
//   fifo_push_msg out  p_bit_width  FIFO write data (istream_msg)
//   fifo_pop      out  1            FIFO read-pointer advance (ostream_rdy)
//   fifo_pop_msg  in   p_bit_width  word at FIFO read pointer (ostream_msg)
//   deq_msg       out  p_bit_width  registered output message
//   deq_val       out  1            output valid
//   deq_rdy       in   1            downstream ready
//   count         out  c_cw         words held in the FIFO (not the out reg)
//   full          out  1            count == p_num_entries
//   empty         out  1            count == 0 and no output word
//   hwm           out  c_cw         max count since reset / last hwm_clr
//   hwm_clr       in   1            synchronous clear of hwm
// -----------------------------------------------------------------------------
module fifo_flow_ctrl #(
  parameter int p_num_entries = 8,
  parameter int p_bit_width   = 32
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [p_bit_width-1:0]           enq_msg,
  input  logic                             enq_val,
  output logic                             enq_rdy,

  output logic                             fifo_push,
  output logic [p_bit_width-1:0]           fifo_push_msg,
  output logic                             fifo_pop,
  input  logic [p_bit_width-1:0]           fifo_pop_msg,

  output logic [p_bit_width-1:0]           deq_msg,
  output logic                             deq_val,
  input  logic                             deq_rdy,

  output logic [$clog2(p_num_entries):0]   count,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(p_num_entries):0]   hwm,
  input  logic                             hwm_clr
);

  localparam int c_cw = $clog2(p_num_entries) + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(p_num_entries);

  logic [c_cw-1:0]        r_count;
  logic [c_cw-1:0]        r_hwm;
  logic                   r_deq_val;
  logic [p_bit_width-1:0] r_deq_msg;

  logic                   w_enq_rdy;
  logic                   w_push;
  logic                   w_pop;
  logic [c_cw-1:0]        w_count_next;
  logic [c_cw-1:0]        w_hwm_next;

  // enq_rdy looks only at count, never at deq_rdy: a word pushed this cycle
  // is not counted yet, so it can never be popped in the same cycle and the
  // FIFO never sees a read and write of the same address.
  assign w_enq_rdy = !reset && (r_count < c_depth);
  assign w_push    = enq_val && w_enq_rdy;

  // Refill the output register whenever it is empty or being drained.
  assign w_pop     = !reset && (r_count != '0) && (!r_deq_val || deq_rdy);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cw'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cw'(1);
    end
  end

  // The mark tracks the post-update count, so a clear restarts it from the
  // occupancy the FIFO will have next cycle rather than from zero.
  always_comb begin
    w_hwm_next = r_hwm;
    if (hwm_clr) begin
      w_hwm_next = w_count_next;
    end else if (w_count_next > r_hwm) begin
      w_hwm_next = w_count_next;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_hwm     <= '0;
      r_deq_val <= 1'b0;
      r_deq_msg <= '0;
    end else begin
      r_count <= w_count_next;
      r_hwm   <= w_hwm_next;
      if (w_pop) begin
        r_deq_val <= 1'b1;
        r_deq_msg <= fifo_pop_msg;
      end else if (r_deq_val && deq_rdy) begin
        // Drained with nothing behind it; deq_msg keeps the last word.
        r_deq_val <= 1'b0;
      end
    end
  end

  assign enq_rdy       = w_enq_rdy;
  assign fifo_push     = w_push;
  assign fifo_push_msg = enq_msg;
  assign fifo_pop      = w_pop;

  assign deq_msg = r_deq_msg;
  assign deq_val = r_deq_val;
  assign count   = r_count;
  assign hwm     = r_hwm;
  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0) && !r_deq_val;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_flow_ctrl
//
// Self-checking bench for fifo_flow_ctrl. A small raw FIFO (memory plus
// pointers) is attached to the push/pop side. Directed table vectors cover
// single-word latency, fill, full-with-pop and drain; hand sequences cover
// mid-stream reset and hwm clear; streaming and random traffic are checked
// every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fifo_flow_ctrl;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = $clog2(N);

  logic          clk;
  logic          reset;
  logic [W-1:0]  enq_msg;
  logic          enq_val;
  logic          enq_rdy;
  logic          fifo_push;
  logic [W-1:0]  fifo_push_msg;
  logic          fifo_pop;
  logic [W-1:0]  fifo_pop_msg;
  logic [W-1:0]  deq_msg;
  logic          deq_val;
  logic          deq_rdy;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [CW-1:0] hwm;
  logic          hwm_clr;

  fifo_flow_ctrl #(.p_num_entries(N), .p_bit_width(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enq_msg      (enq_msg),
    .enq_val      (enq_val),
    .enq_rdy      (enq_rdy),
    .fifo_push    (fifo_push),
    .fifo_push_msg(fifo_push_msg),
    .fifo_pop     (fifo_pop),
    .fifo_pop_msg (fifo_pop_msg),
    .deq_msg      (deq_msg),
    .deq_val      (deq_val),
    .deq_rdy      (deq_rdy),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .hwm          (hwm),
    .hwm_clr      (hwm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached raw FIFO: unguarded, synchronous pointer reset.
  logic [W-1:0]  mem [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) begin
        mem[wr_ptr] <= fifo_push_msg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  assign fifo_pop_msg = mem[rd_ptr];

  // Reference model: words waiting in the FIFO plus the output slot.
  logic [W-1:0] m_q [$];
  logic         m_ov;
  logic [W-1:0] m_om;
  int           m_hwm;

  int n_vec;
  int n_mis;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov  = 1'b0;
    m_om  = '0;
    m_hwm = 0;
  endtask

  // One clock of the reference model, using the inputs currently applied.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    int nxt;
    do_pop  = (m_q.size() != 0) && (!m_ov || deq_rdy);
    do_push = enq_val && (m_q.size() < N);
    if (do_pop) begin
      m_om = m_q.pop_front();
      m_ov = 1'b1;
    end else if (m_ov && deq_rdy) begin
      m_ov = 1'b0;
    end
    // Pushed after the pop: a word entering now cannot leave this cycle.
    if (do_push) m_q.push_back(enq_msg);
    nxt = m_q.size();
    if (hwm_clr)          m_hwm = nxt;
    else if (nxt > m_hwm) m_hwm = nxt;
  endtask

  task automatic check_model();
    int qs;
    bit e_rdy;
    qs    = m_q.size();
    e_rdy = (qs < N);
    check("enq_rdy",       enq_rdy,       e_rdy);
    check("fifo_push",     fifo_push,     enq_val && e_rdy);
    check("fifo_push_msg", fifo_push_msg, enq_msg);
    check("fifo_pop",      fifo_pop,      (qs != 0) && (!m_ov || deq_rdy));
    check("pop_at_zero",   fifo_pop && (count == 0), 1'b0);
    check("deq_val",       deq_val,       m_ov);
    check("deq_msg",       deq_msg,       m_om);
    check("count",         count,         qs);
    check("hwm",           hwm,           m_hwm);
    check("full",          full,          qs == N);
    check("empty",         empty,         (qs == 0) && !m_ov);
  endtask

  // Inputs are already applied; check mid-cycle, then advance one edge.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic ev, input logic [W-1:0] msg, input logic dr, input logic clr);
    enq_val = ev;
    enq_msg = msg;
    deq_rdy = dr;
    hwm_clr = clr;
  endtask

  typedef struct {
    logic         ev;
    logic [W-1:0] msg;
    logic         dr;
    logic         clr;
    logic         e_rdy;
    logic         e_push;
    logic         e_pop;
    logic         e_dv;
    logic [W-1:0] e_msg;
    int           e_count;
    int           e_hwm;
    logic         e_full;
    logic         e_empty;
  } vec_t;

  function automatic vec_t mk(logic ev, logic [W-1:0] msg, logic dr, logic clr,
                              logic rdy, logic push, logic pop, logic dv,
                              logic [W-1:0] dmsg, int cnt, int hw,
                              logic fl, logic em);
    vec_t v;
    v.ev = ev; v.msg = msg; v.dr = dr; v.clr = clr;
    v.e_rdy = rdy; v.e_push = push; v.e_pop = pop; v.e_dv = dv;
    v.e_msg = dmsg; v.e_count = cnt; v.e_hwm = hw;
    v.e_full = fl; v.e_empty = em;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    n_vec = 0;
    n_mis = 0;
    model_reset();

    // Single word: enqueue, pop next cycle, visible two cycles after enqueue.
    tbl.push_back(mk(1, 32'hA5A5_0001, 1, 0,  1, 1, 0, 0, 32'h0,          0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,         1, 0,  1, 0, 1, 0, 32'h0,          1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,         1, 0,  1, 0, 0, 1, 32'hA5A5_0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,         0, 0,  1, 0, 0, 0, 32'hA5A5_0001, 0, 1, 0, 1));
    // Fill with deq_rdy=0: words 0..8 accepted, word 9 refused at full.
    tbl.push_back(mk(1, 32'd0,         0, 0,  1, 1, 0, 0, 32'hA5A5_0001, 0, 1, 0, 1));
    tbl.push_back(mk(1, 32'd1,         0, 0,  1, 1, 1, 0, 32'hA5A5_0001, 1, 1, 0, 0));
    for (int k = 2; k <= 9; k++) begin
      tbl.push_back(mk(1, W'(k), 0, 0, k <= 8, k <= 8, 0, 1, 32'd0,
                       k - 1, (k < 3) ? 1 : k - 1, k == 9, 0));
    end
    // Full with a simultaneous pop: enq_rdy stays low, returns next cycle.
    tbl.push_back(mk(1, 32'd9,         1, 0,  0, 0, 1, 1, 32'd0,          8, 8, 1, 0));
    tbl.push_back(mk(1, 32'd9,         0, 0,  1, 1, 0, 1, 32'd1,          7, 8, 0, 0));
    tbl.push_back(mk(0, 32'd0,         1, 0,  0, 0, 1, 1, 32'd1,          8, 8, 1, 0));
    // Drain in order, one word per cycle.
    for (int j = 1; j <= 8; j++) begin
      tbl.push_back(mk(0, 32'd0, 1, 0, 1, 0, j < 8, 1, W'(j + 1), 8 - j, 8, 0, 0));
    end
    tbl.push_back(mk(0, 32'd0,         0, 0,  1, 0, 0, 0, 32'd9,          0, 8, 0, 1));

    // ---- Reset from power-up, inputs active to prove the gating ----
    reset = 1'b1;
    drive(1, 32'hDEAD_BEEF, 1, 0);
    @(negedge clk);
    check("rst_enq_rdy",   enq_rdy,   1'b0);
    check("rst_fifo_push", fifo_push, 1'b0);
    check("rst_fifo_pop",  fifo_pop,  1'b0);
    check("rst_deq_val",   deq_val,   1'b0);
    check("rst_count",     count,     0);
    check("rst_hwm",       hwm,       0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0);
    reset = 1'b0;
    #1;
    check("post_rst_enq_rdy", enq_rdy, 1'b1);
    check("post_rst_empty",   empty,   1'b1);
    check("post_rst_deq_msg", deq_msg, 32'h0);

    // ---- Directed table ----
    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].msg, tbl[i].dr, tbl[i].clr);
      @(negedge clk);
      check($sformatf("tbl%0d_enq_rdy", i),   enq_rdy,   tbl[i].e_rdy);
      check($sformatf("tbl%0d_fifo_push", i), fifo_push, tbl[i].e_push);
      check($sformatf("tbl%0d_fifo_pop", i),  fifo_pop,  tbl[i].e_pop);
      check($sformatf("tbl%0d_deq_val", i),   deq_val,   tbl[i].e_dv);
      check($sformatf("tbl%0d_deq_msg", i),   deq_msg,   tbl[i].e_msg);
      check($sformatf("tbl%0d_count", i),     count,     tbl[i].e_count);
      check($sformatf("tbl%0d_hwm", i),       hwm,       tbl[i].e_hwm);
      check($sformatf("tbl%0d_full", i),      full,      tbl[i].e_full);
      check($sformatf("tbl%0d_empty", i),     empty,     tbl[i].e_empty);
      @(posedge clk);
      model_step();
      #1;
    end

    // ---- Mid-stream reset with 3 words buffered ----
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC000_0000 + W'(i), 0, 0);
      tick();
    end
    check("mid_count_before", count, 2);
    check("mid_dval_before",  deq_val, 1'b1);
    drive(1, 32'hC000_00FF, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_deq_val",   deq_val,   1'b0);
    check("mid_rst_count",     count,     0);
    check("mid_rst_hwm",       hwm,       0);
    check("mid_rst_deq_msg",   deq_msg,   32'h0);
    check("mid_rst_enq_rdy",   enq_rdy,   1'b0);
    check("mid_rst_fifo_push", fifo_push, 1'b0);
    check("mid_rst_fifo_pop",  fifo_pop,  1'b0);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_post_enq_rdy", enq_rdy, 1'b1);
    check("mid_post_empty",   empty,   1'b1);
    check("mid_post_count",   count,   0);
    check("mid_post_hwm",     hwm,     0);

    // ---- High-water mark: reach 5, drain to 2, clear while pushing ----
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hB000_0000 + W'(i), 0, 0);
      tick();
    end
    check("hwm_reach_count", count, 5);
    check("hwm_reach_hwm",   hwm,   5);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 1, 0);
      tick();
    end
    check("hwm_drain_count", count, 2);
    check("hwm_drain_hwm",   hwm,   5);
    drive(1, 32'hB000_0010, 0, 1);
    tick();
    check("hwm_clr_value", hwm, 3);
    drive(0, 32'h0, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    check("pre_stream_empty", empty, 1'b1);

    // ---- Streaming across pointer wrap ----
    for (int i = 0; i < 40; i++) begin
      drive(1, 32'h5000_0000 + W'(i), 1, 0);
      tick();
      check("stream_count_le1", count <= 1, 1'b1);
    end
    check("stream_deq_msg_last", deq_msg, 32'h5000_0026);

    // ---- Random traffic against the model ----
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 15) == 0);
      tick();
    end
    drive(0, 32'h0, 1, 0);
    for (int i = 0; i < N + 2; i++) tick();
    check("final_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
